// File: rtl/rtc_burst_rw.sv
// Burst engine for a multiplexed address/data RTC bus: one start runs NUM_REGS
// register transactions at incrementing addresses, reading into or writing from a flat bank.
module rtc_burst_rw #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                NUM_REGS  = 9,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h21,
    parameter int                T_PHASE   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode,
    input  logic                         abort,
    input  logic [NUM_REGS*DATA_W-1:0]   wr_data,
    output logic [NUM_REGS*DATA_W-1:0]   rd_data,
    input  logic [DATA_W-1:0]            ad_in,
    output logic [DATA_W-1:0]            ad_out,
    output logic                         ad_oe,
    output logic                         cs_n,
    output logic                         rd_n,
    output logic                         wr_n,
    output logic                         a_d,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(T_PHASE - 1);

    // Bus phases are numbered consecutively so the successor of A_SET..D_HLD is state+1.
    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_A_SET       = 4'd1;
    localparam logic [3:0] S_A_STB       = 4'd2;
    localparam logic [3:0] S_A_HLD       = 4'd3;
    localparam logic [3:0] S_GAP         = 4'd4;
    localparam logic [3:0] S_D_SET       = 4'd5;
    localparam logic [3:0] S_D_STB       = 4'd6;
    localparam logic [3:0] S_D_HLD       = 4'd7;
    localparam logic [3:0] S_RECOV       = 4'd8;
    localparam logic [3:0] S_DONE        = 4'd9;
    localparam logic [3:0] S_ABORT_RECOV = 4'd10;
    localparam logic [3:0] S_ABORT       = 4'd11;

    logic [3:0]                 r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_mode;
    logic [NUM_REGS*DATA_W-1:0] r_wsnap;
    logic [NUM_REGS*DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0]          r_ad_out;
    logic                       r_ad_oe, r_cs_n, r_rd_n, r_wr_n, r_a_d;
    logic                       r_busy, r_done, r_aborted;

    logic [3:0]                 w_state_nxt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic [IDX_W-1:0]           w_idx_nxt;
    logic                       w_mode_nxt;
    logic                       w_last;
    logic                       w_capture;
    logic [ADDR_W-1:0]          w_addr;
    logic [DATA_W-1:0]          w_wslot;
    logic [DATA_W-1:0]          w_ad_out_nxt;
    logic                       w_ad_oe_nxt, w_cs_n_nxt, w_rd_n_nxt, w_wr_n_nxt, w_a_d_nxt;

    assign w_last     = (r_cnt == LAST_CNT);
    assign w_mode_nxt = (r_state == S_IDLE && start) ? mode : r_mode;
    assign w_capture  = (r_state == S_D_STB) && w_last && !r_mode && !abort;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_A_SET;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            S_A_SET, S_A_STB, S_A_HLD, S_GAP, S_D_SET, S_D_STB, S_D_HLD, S_RECOV: begin
                if (abort) begin
                    w_state_nxt = S_ABORT_RECOV;
                    w_cnt_nxt   = '0;
                end else if (w_last) begin
                    w_cnt_nxt = '0;
                    if (r_state != S_RECOV) begin
                        w_state_nxt = r_state + 4'd1;
                    end else if (r_idx != LAST_IDX) begin
                        w_state_nxt = S_A_SET;
                        w_idx_nxt   = r_idx + 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_ABORT_RECOV: begin
                if (w_last) begin
                    w_state_nxt = S_ABORT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Bus drive values are decoded from the next state so every pad output comes straight from a flop.
    always_comb begin
        w_addr  = BASE_ADDR + ADDR_W'(w_idx_nxt);
        w_wslot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) w_wslot = r_wsnap[i*DATA_W +: DATA_W];
        end
        w_cs_n_nxt   = 1'b1;
        w_rd_n_nxt   = 1'b1;
        w_wr_n_nxt   = 1'b1;
        w_a_d_nxt    = 1'b1;
        w_ad_oe_nxt  = 1'b0;
        w_ad_out_nxt = '0;
        case (w_state_nxt)
            S_A_SET, S_A_STB, S_A_HLD: begin
                w_cs_n_nxt   = 1'b0;
                w_a_d_nxt    = 1'b0;
                w_ad_oe_nxt  = 1'b1;
                w_ad_out_nxt = DATA_W'(w_addr);
                w_wr_n_nxt   = (w_state_nxt != S_A_STB);
            end
            S_D_SET, S_D_STB, S_D_HLD: begin
                w_cs_n_nxt = 1'b0;
                if (w_mode_nxt) begin
                    w_ad_oe_nxt  = 1'b1;
                    w_ad_out_nxt = w_wslot;
                    w_wr_n_nxt   = (w_state_nxt != S_D_STB);
                end else begin
                    w_rd_n_nxt = (w_state_nxt != S_D_STB);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_mode    <= 1'b0;
            r_rd_data <= '0;
            r_ad_out  <= '0;
            r_ad_oe   <= 1'b0;
            r_cs_n    <= 1'b1;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_a_d     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_mode    <= w_mode_nxt;
            r_ad_out  <= w_ad_out_nxt;
            r_ad_oe   <= w_ad_oe_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_rd_n    <= w_rd_n_nxt;
            r_wr_n    <= w_wr_n_nxt;
            r_a_d     <= w_a_d_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
            r_aborted <= (w_state_nxt == S_ABORT);
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_capture && r_idx == IDX_W'(i)) r_rd_data[i*DATA_W +: DATA_W] <= ad_in;
            end
        end
    end

    // Write data snapshot: only meaningful once a burst has started, so it carries no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) r_wsnap <= wr_data;
    end

    assign rd_data = r_rd_data;
    assign ad_out  = r_ad_out;
    assign ad_oe   = r_ad_oe;
    assign cs_n    = r_cs_n;
    assign rd_n    = r_rd_n;
    assign wr_n    = r_wr_n;
    assign a_d     = r_a_d;
    assign busy    = r_busy;
    assign done    = r_done;
    assign aborted = r_aborted;

endmodule

// File: tb/tb_rtc_burst_rw.sv
// Bench for rtc_burst_rw: two instances (base 8'h21 and 8'hFE) with a bus model that
// answers reads with ~address; bus events are checked against queued expectations.
module tb_rtc_burst_rw;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, mode, abort;
    logic [23:0] wr_data, rd_data;
    logic [7:0]  ad_in, ad_out;
    logic        ad_oe, cs_n, rd_n, wr_n, a_d, busy, done, aborted;

    logic        start2, mode2, abort2;
    logic [23:0] wr_data2, rd_data2;
    logic [7:0]  ad_in2, ad_out2;
    logic        ad_oe2, cs_n2, rd_n2, wr_n2, a_d2, busy2, done2, aborted2;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_addr[$];
    logic [7:0] exp_wdata[$];
    logic [7:0] exp_addr2[$];

    logic [7:0] lat_addr  = 8'h00;
    logic [7:0] lat_addr2 = 8'h00;
    logic       prev_wr_n  = 1'b1;
    logic       prev_wr_n2 = 1'b1;
    int         wr_low     = 0;
    int         rd_low_cnt = 0;
    logic [7:0] e1, e2;

    assign ad_in  = ~lat_addr;
    assign ad_in2 = ~lat_addr2;

    always #5 clk = ~clk;

    rtc_burst_rw #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(3), .BASE_ADDR(8'h21), .T_PHASE(2)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .wr_data(wr_data), .rd_data(rd_data), .ad_in(ad_in), .ad_out(ad_out),
        .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
        .busy(busy), .done(done), .aborted(aborted)
    );

    rtc_burst_rw #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(3), .BASE_ADDR(8'hFE), .T_PHASE(2)) u_dut_wrap (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2), .abort(abort2),
        .wr_data(wr_data2), .rd_data(rd_data2), .ad_in(ad_in2), .ad_out(ad_out2),
        .ad_oe(ad_oe2), .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2), .a_d(a_d2),
        .busy(busy2), .done(done2), .aborted(aborted2)
    );

    // Bus model and monitor for the base-8'h21 instance.
    always @(negedge clk) begin
        if (reset) begin
            wr_low = 0;
        end else begin
            total++;
            if (!rd_n && ad_oe) begin bad++; $display("FAIL rd_while_oe: rd_n=%b ad_oe=%b required not both active", rd_n, ad_oe); end
            total++;
            if (!rd_n && !wr_n) begin bad++; $display("FAIL rd_wr_overlap: rd_n=%b wr_n=%b required not both low", rd_n, wr_n); end
            total++;
            if ((!rd_n || !wr_n) && cs_n) begin bad++; $display("FAIL strobe_without_cs: cs_n=%b required 0", cs_n); end
            if (!rd_n) rd_low_cnt++;
            if (!cs_n && !a_d && !wr_n) lat_addr = ad_out;
            if (!wr_n && prev_wr_n) begin
                total++;
                if (!a_d) begin
                    if (exp_addr.size() == 0) begin bad++; $display("FAIL addr_extra: got=%h required none", ad_out); end
                    else begin
                        e1 = exp_addr.pop_front();
                        if (ad_out !== e1) begin bad++; $display("FAIL addr_phase: got=%h required=%h", ad_out, e1); end
                    end
                end else begin
                    if (exp_wdata.size() == 0) begin bad++; $display("FAIL wdata_extra: got=%h required none", ad_out); end
                    else begin
                        e1 = exp_wdata.pop_front();
                        if (ad_out !== e1) begin bad++; $display("FAIL write_data: got=%h required=%h", ad_out, e1); end
                    end
                end
            end
            if (!wr_n) wr_low++;
            else if (!prev_wr_n) begin
                total++;
                if (wr_low != 2) begin bad++; $display("FAIL wr_pulse_width: got=%0d required=2", wr_low); end
                wr_low = 0;
            end
        end
        prev_wr_n = wr_n;
    end

    // Bus model and address monitor for the base-8'hFE instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (!cs_n2 && !a_d2 && !wr_n2) lat_addr2 = ad_out2;
            if (!wr_n2 && prev_wr_n2 && !a_d2) begin
                total++;
                if (exp_addr2.size() == 0) begin bad++; $display("FAIL wrap_addr_extra: got=%h required none", ad_out2); end
                else begin
                    e2 = exp_addr2.pop_front();
                    if (ad_out2 !== e2) begin bad++; $display("FAIL wrap_addr_phase: got=%h required=%h", ad_out2, e2); end
                end
            end
        end
        prev_wr_n2 = wr_n2;
    end

    task automatic pulse_start(input bit sel);
        @(posedge clk); #1;
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
    endtask

    task automatic run_burst(input bit sel, input int inject_at, output int cycles,
                             output int done_cyc, output int done_cnt, output int ab_cnt);
        cycles = 0; done_cyc = 0; done_cnt = 0; ab_cnt = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!(sel ? busy2 : busy)) break;
            cycles++;
            if (sel ? done2 : done) begin done_cnt++; done_cyc = cycles; end
            if (sel ? aborted2 : aborted) ab_cnt++;
            if (cycles == inject_at) begin
                if (sel) start2 = 1'b1; else start = 1'b1;
            end else begin
                start = 1'b0; start2 = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        total++; if (cs_n !== 1'b1)   begin bad++; $display("FAIL reset_cs_n: got=%b required=1", cs_n); end
        total++; if (rd_n !== 1'b1)   begin bad++; $display("FAIL reset_rd_n: got=%b required=1", rd_n); end
        total++; if (wr_n !== 1'b1)   begin bad++; $display("FAIL reset_wr_n: got=%b required=1", wr_n); end
        total++; if (a_d !== 1'b1)    begin bad++; $display("FAIL reset_a_d: got=%b required=1", a_d); end
        total++; if (ad_oe !== 1'b0)  begin bad++; $display("FAIL reset_ad_oe: got=%b required=0", ad_oe); end
        total++; if (ad_out !== 8'h0) begin bad++; $display("FAIL reset_ad_out: got=%h required=00", ad_out); end
        total++; if ({busy, done, aborted} !== 3'b000) begin bad++; $display("FAIL reset_status: got=%b required=000", {busy, done, aborted}); end
        total++; if (rd_data !== 24'h0) begin bad++; $display("FAIL reset_rd_data: got=%h required=000000", rd_data); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_abort;
        int  falls;
        bit  prev, found, done_seen;
        logic [3:0] ab_seen, busy_seen, idle_seen;
        falls = 0; prev = 1'b1; found = 1'b0; done_seen = 1'b0;
        exp_addr.push_back(8'h21); exp_addr.push_back(8'h22);
        mode = 1'b0;
        pulse_start(1'b0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
            if (!rd_n && prev) falls++;
            prev = rd_n;
            if (falls == 2) begin found = 1'b1; break; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL abort_reach_dstb: got=%0d read strobes required=2", falls); end
        else begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                ab_seen[c]   = aborted;
                busy_seen[c] = busy;
                idle_seen[c] = cs_n && !ad_oe && rd_n && wr_n;
                if (done) done_seen = 1'b1;
            end
            total++; if (ab_seen !== 4'b0100)   begin bad++; $display("FAIL abort_pulse: got=%b required=0100", ab_seen); end
            total++; if (busy_seen !== 4'b0111) begin bad++; $display("FAIL abort_busy: got=%b required=0111", busy_seen); end
            total++; if (idle_seen !== 4'b1111) begin bad++; $display("FAIL abort_bus_idle: got=%b required=1111", idle_seen); end
        end
        total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got=%b required=0", done_seen); end
        total++; if (rd_data !== 24'h0000DE) begin bad++; $display("FAIL abort_rd_data: got=%h required=0000de", rd_data); end
        total++; if (exp_addr.size() != 0) begin bad++; $display("FAIL abort_addr_left: got=%0d required=0", exp_addr.size()); end
        exp_addr.delete();
    endtask

    task automatic test_read;
        int cyc, dcyc, dcnt, acnt;
        exp_addr.push_back(8'h21); exp_addr.push_back(8'h22); exp_addr.push_back(8'h23);
        mode = 1'b0;
        pulse_start(1'b0);
        run_burst(1'b0, -1, cyc, dcyc, dcnt, acnt);
        total++; if (cyc != 49)  begin bad++; $display("FAIL read_busy_len: got=%0d required=49", cyc); end
        total++; if (dcyc != 49 || dcnt != 1) begin bad++; $display("FAIL read_done: got=cycle %0d count %0d required=cycle 49 count 1", dcyc, dcnt); end
        total++; if (acnt != 0) begin bad++; $display("FAIL read_no_abort: got=%0d required=0", acnt); end
        total++; if (rd_data !== 24'hDCDDDE) begin bad++; $display("FAIL read_rd_data: got=%h required=dcddde", rd_data); end
        total++; if (exp_addr.size() != 0) begin bad++; $display("FAIL read_addr_left: got=%0d required=0", exp_addr.size()); end
        exp_addr.delete();
    endtask

    task automatic test_write;
        int cyc, dcyc, dcnt, acnt;
        exp_addr.push_back(8'h21);  exp_addr.push_back(8'h22);  exp_addr.push_back(8'h23);
        exp_wdata.push_back(8'h11); exp_wdata.push_back(8'h22); exp_wdata.push_back(8'h33);
        @(posedge clk); #1;
        wr_data = 24'h332211; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wr_data = 24'h0; mode = 1'b0;
        rd_low_cnt = 0;
        run_burst(1'b0, -1, cyc, dcyc, dcnt, acnt);
        total++; if (cyc != 49 || dcnt != 1) begin bad++; $display("FAIL write_busy_done: got=%0d/%0d required=49/1", cyc, dcnt); end
        total++; if (rd_low_cnt != 0) begin bad++; $display("FAIL write_rd_activity: got=%0d required=0", rd_low_cnt); end
        total++; if (rd_data !== 24'hDCDDDE) begin bad++; $display("FAIL write_rd_data_kept: got=%h required=dcddde", rd_data); end
        total++; if (exp_wdata.size() != 0 || exp_addr.size() != 0) begin bad++; $display("FAIL write_events_left: got=%0d/%0d required=0/0", exp_addr.size(), exp_wdata.size()); end
        exp_addr.delete(); exp_wdata.delete();
    endtask

    task automatic test_wrap;
        int  cyc, dcyc, dcnt, acnt;
        bit  found, done_seen;
        int  ab_cnt;
        found = 1'b0; done_seen = 1'b0; ab_cnt = 0;
        // Abort landing exactly on the capture edge of the first read slot.
        exp_addr2.push_back(8'hFE);
        pulse_start(1'b1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!rd_n2) begin found = 1'b1; break; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL capture_abort_reach: got=no read strobe required=read strobe"); end
        else begin
            @(negedge clk);
            abort2 = 1'b1;
            @(posedge clk); #1;
            abort2 = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (done2) done_seen = 1'b1;
                if (aborted2) ab_cnt++;
                if (!busy2) break;
            end
            total++; if (rd_data2 !== 24'h0) begin bad++; $display("FAIL capture_abort_rd_data: got=%h required=000000", rd_data2); end
            total++; if (ab_cnt != 1 || done_seen) begin bad++; $display("FAIL capture_abort_pulses: got=aborted %0d done %b required=1 0", ab_cnt, done_seen); end
        end
        exp_addr2.delete();
        // Full wrapping burst with a stray start in the middle.
        exp_addr2.push_back(8'hFE); exp_addr2.push_back(8'hFF); exp_addr2.push_back(8'h00);
        pulse_start(1'b1);
        run_burst(1'b1, 20, cyc, dcyc, dcnt, acnt);
        total++; if (cyc != 49 || dcyc != 49 || dcnt != 1) begin bad++; $display("FAIL wrap_busy_done: got=%0d/%0d/%0d required=49/49/1", cyc, dcyc, dcnt); end
        total++; if (rd_data2 !== 24'hFF0001) begin bad++; $display("FAIL wrap_rd_data: got=%h required=ff0001", rd_data2); end
        total++; if (exp_addr2.size() != 0) begin bad++; $display("FAIL wrap_addr_left: got=%0d required=0", exp_addr2.size()); end
        exp_addr2.delete();
        @(negedge clk);
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL wrap_no_restart: got=%b required=0", busy2); end
    endtask

    task automatic test_async_reset;
        int cyc, dcyc, dcnt, acnt;
        bit found, pulse_seen;
        found = 1'b0; pulse_seen = 1'b0;
        exp_addr.push_back(8'h21); exp_addr.push_back(8'h22); exp_addr.push_back(8'h23);
        mode = 1'b0;
        pulse_start(1'b0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!rd_n) begin found = 1'b1; break; end
        end
        #2 reset = 1'b1;
        #1;
        total++; if (!found) begin bad++; $display("FAIL areset_reach_dstb: got=no read strobe required=read strobe"); end
        total++; if ({cs_n, rd_n, wr_n, ad_oe} !== 4'b1110) begin bad++; $display("FAIL areset_bus: got=%b required=1110", {cs_n, rd_n, wr_n, ad_oe}); end
        total++; if (rd_data !== 24'h0 || busy !== 1'b0) begin bad++; $display("FAIL areset_state: got=%h busy=%b required=000000 busy=0", rd_data, busy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || aborted) pulse_seen = 1'b1;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_addr.delete(); exp_wdata.delete();
        @(negedge clk);
        if (done || aborted) pulse_seen = 1'b1;
        total++; if (pulse_seen) begin bad++; $display("FAIL areset_no_pulse: got=1 required=0"); end
        exp_addr.push_back(8'h21); exp_addr.push_back(8'h22); exp_addr.push_back(8'h23);
        pulse_start(1'b0);
        run_burst(1'b0, -1, cyc, dcyc, dcnt, acnt);
        total++; if (cyc != 49 || dcnt != 1 || acnt != 0) begin bad++; $display("FAIL areset_rerun: got=%0d/%0d/%0d required=49/1/0", cyc, dcnt, acnt); end
        total++; if (rd_data !== 24'hDCDDDE) begin bad++; $display("FAIL areset_rerun_data: got=%h required=dcddde", rd_data); end
        total++; if (exp_addr.size() != 0) begin bad++; $display("FAIL areset_addr_left: got=%0d required=0", exp_addr.size()); end
        exp_addr.delete();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; mode = 1'b0; abort = 1'b0; wr_data = 24'h0;
        start2 = 1'b0; mode2 = 1'b0; abort2 = 1'b0; wr_data2 = 24'h0;
        test_reset();
        test_abort();
        test_read();
        test_write();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
